// File: rtl/cur_blk_fetch_ctrl.sv
// Current-macroblock fetch sequencer: walks one BLK_W x BLK_H block out of a 64-bit
// combinational frame memory into a valid/ready stage. Optional bounds check: CUR_FETCH_BOUNDS_CHK_EN.
module cur_blk_fetch_ctrl #(
  parameter int BLK_W  = 16,
  parameter int BLK_H  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     frame_base,
  input  logic [15:0]           frame_width,
  input  logic [11:0]           mb_x,
  input  logic [11:0]           mb_y,
`ifdef CUR_FETCH_BOUNDS_CHK_EN
  input  logic [15:0]           frame_height,
  output logic                  err,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [63:0]           mem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_data,
  output logic [((BLK_H > 1) ? $clog2(BLK_H) : 1)-1:0]         out_row,
  output logic [((BLK_W / 8 > 1) ? $clog2(BLK_W / 8) : 1)-1:0] out_col,
  output logic                  out_last
);

  localparam int WPR = BLK_W / 8;
  localparam int RW  = (BLK_H > 1) ? $clog2(BLK_H) : 1;
  localparam int CW  = (WPR > 1) ? $clog2(WPR) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DRAIN_ERR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] row_ptr;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic              capture, at_end, col_end, hs, chk_fail, accept;
  logic [63:0]       blk_off;

  // Full-width products; only the final sum is truncated to ADDR_W.
  always_comb blk_off = 64'(mb_y) * 64'(BLK_H) * 64'(frame_width) + 64'(mb_x) * 64'(BLK_W);

`ifdef CUR_FETCH_BOUNDS_CHK_EN
  always_comb chk_fail = ((int'(mb_x) + 1) * BLK_W > int'(frame_width)) ||
                         ((int'(mb_y) + 1) * BLK_H > int'(frame_height));
`else
  assign chk_fail = 1'b0;
`endif

  assign col_end = (col == CW'(WPR - 1));
  assign at_end  = col_end && (row == RW'(BLK_H - 1));
  assign hs      = out_valid && out_ready;
  assign accept  = (state == IDLE) && start;
  assign busy    = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_addr  = '0;
    capture   = 1'b0;
    case (state)
      IDLE:      if (start) state_nxt = chk_fail ? DRAIN_ERR : FETCH;
      FETCH: begin
        mem_en   = !out_valid || out_ready;
        mem_addr = row_ptr + (ADDR_W'(col) << 3);
        capture  = mem_en;
        if (mem_en && at_end) state_nxt = DRAIN;
      end
      DRAIN:     if (hs) state_nxt = IDLE;
      DRAIN_ERR: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_ptr   <= '0;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
`ifdef CUR_FETCH_BOUNDS_CHK_EN
      err       <= 1'b0;
`endif
    end else begin
      done <= ((state == DRAIN) && hs) || (accept && chk_fail);
`ifdef CUR_FETCH_BOUNDS_CHK_EN
      err  <= accept && chk_fail;
`endif
      if (accept) begin
        row_ptr <= frame_base + blk_off[ADDR_W-1:0];
        row     <= '0;
        col     <= '0;
      end
      if (capture) begin
        out_data  <= mem_data;
        out_row   <= row;
        out_col   <= col;
        out_last  <= at_end;
        out_valid <= 1'b1;
        if (col_end) begin
          col     <= '0;
          row     <= row + RW'(1);
          row_ptr <= row_ptr + ADDR_W'(frame_width);
        end else begin
          col     <= col + CW'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cur_blk_fetch_ctrl.sv
// Scoreboard bench for cur_blk_fetch_ctrl: a frame-memory model, expected-word queue
// filled from block geometry, and a monitor that pops on every output handshake.
module tb_cur_blk_fetch_ctrl;
  localparam int BLK_W = 16, BLK_H = 16, AW = 32, NW = BLK_W * BLK_H / 8;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] frame_base = '0;
  logic [15:0]   frame_width = '0, frame_height = 16'hFFFF;
  logic [11:0]   mb_x = '0, mb_y = '0;
  logic          busy, done, mem_en, out_valid, out_last;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_data, out_data;
  logic [3:0]    out_row;
  logic [0:0]    out_col;
`ifdef CUR_FETCH_BOUNDS_CHK_EN
  logic          err;
`endif

  cur_blk_fetch_ctrl #(.BLK_W(BLK_W), .BLK_H(BLK_H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_base(frame_base),
    .frame_width(frame_width), .mb_x(mb_x), .mb_y(mb_y),
`ifdef CUR_FETCH_BOUNDS_CHK_EN
    .frame_height(frame_height), .err(err),
`endif
    .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last));

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; int r; int c; bit l; } exp_t;
  exp_t          expq[$];
  logic [AW-1:0] addr_log[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int nword = 0, men_cnt = 0, done_cnt = 0, done_cyc = -1, err_cnt = 0, err_cyc = -1;
  int t_start = 0, first_valid = -1, first_busy = -1, rmode = 0;
  bit prev_stall = 0;
  logic [63:0] prev_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory: each byte is a hash of its own byte address.
  function automatic logic [63:0] mem_fn(input logic [31:0] a);
    logic [63:0] d;
    logic [31:0] b;
    for (int k = 0; k < 8; k++) begin
      b = (a + 32'(k)) * 32'h9E3779B1;
      d[8*k +: 8] = b[31:24];
    end
    return d;
  endfunction

  always_comb mem_data = mem_fn(mem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit oob(input int mx, input int my, input int fw, input int fh);
`ifdef CUR_FETCH_BOUNDS_CHK_EN
    return ((mx + 1) * BLK_W > fw) || ((my + 1) * BLK_H > fh);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: word (r,c) lives at block origin + r*stride + 8*c, modulo 2^32.
  task automatic push_block(input logic [31:0] base, input int fw, input int mx, input int my);
    logic [31:0] a;
    for (int r = 0; r < BLK_H; r++)
      for (int c = 0; c < BLK_W / 8; c++) begin
        a = base + 32'(my * BLK_H) * 32'(fw) + 32'(mx * BLK_W) + 32'(r) * 32'(fw) + 32'(c * 8);
        expq.push_back('{mem_fn(a), r, c, (r == BLK_H - 1) && (c == BLK_W / 8 - 1)});
      end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (out_valid && out_ready) begin
        nword++;
        if (expq.size() == 0) check("unexpected_word", 1'b1, 1'b0);
        else begin
          exp_t e;
          e = expq.pop_front();
          check("word_data", out_data, e.d);
          check("word_row", 64'(out_row), 64'(e.r));
          check("word_col", 64'(out_col), 64'(e.c));
          check("word_last", 64'(out_last), 64'(e.l));
        end
      end
      if (out_valid && !out_ready) check("stall_mem_en", 64'(mem_en), 64'd0);
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, prev_data);
      end
      if (!busy) check("idle_mem", {31'd0, mem_en, mem_addr}, 64'd0);
      if (mem_en) begin addr_log.push_back(mem_addr); men_cnt++; end
      if (done) begin done_cnt++; done_cyc = cyc; end
`ifdef CUR_FETCH_BOUNDS_CHK_EN
      if (err) begin err_cnt++; err_cyc = cyc; end
`endif
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (busy && first_busy < 0) first_busy = cyc;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Consumer ready driver: 0 = always ready, 1 = random, 2 = 5-cycle stall mid-block
  always @(posedge clk) begin
    #2;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = !((cyc - t_start) inside {[12:16]});
    endcase
  end

  task automatic do_start(input logic [31:0] base, input int fw, input int fh, input int mx, input int my);
    @(posedge clk); #2;
    frame_base = base; frame_width = 16'(fw); frame_height = 16'(fh);
    mb_x = 12'(mx); mb_y = 12'(my);
    start = 1'b1; t_start = cyc; first_valid = -1; first_busy = -1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(posedge clk);
    check("done_timeout", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic run_fetch(input logic [31:0] base, input int fw, input int fh, input int mx, input int my);
    int d0, w0, m0, e0;
    bit bad;
    addr_log.delete();
    d0 = done_cnt; w0 = nword; m0 = men_cnt; e0 = err_cnt;
    bad = oob(mx, my, fw, fh);
    if (!bad) push_block(base, fw, mx, my);
    do_start(base, fw, fh, mx, my);
    wait_done(d0 + 1, 400);
    repeat (3) @(posedge clk);
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("queue_empty", 64'(expq.size()), 64'd0);
    check("word_count", 64'(nword - w0), bad ? 64'd0 : 64'(NW));
    check("mem_en_count", 64'(men_cnt - m0), bad ? 64'd0 : 64'(NW));
`ifdef CUR_FETCH_BOUNDS_CHK_EN
    check("err_pulse", 64'(err_cnt - e0), 64'(bad));
    if (bad) begin
      check("err_done_lat", 64'(done_cyc - t_start), 64'd1);
      check("err_lat", 64'(err_cyc - t_start), 64'd1);
    end
`endif
    if (!bad && rmode == 0) check("done_lat", 64'(done_cyc - t_start), 64'(NW + 2));
    expq.delete();
  endtask

  initial begin
    int d0, w0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, mem_en, out_valid, out_last}, 64'd0);
    check("reset_data", out_data, 64'd0);
    check("reset_addr", 64'(mem_addr), 64'd0);
    #1 rst = 1'b0;

    // Basic fetch with address sequence and latency
    rmode = 0;
    run_fetch(32'd0, 64, 16'hFFFF, 1, 2);
    check("first_busy", 64'(first_busy - t_start), 64'd1);
    check("first_valid", 64'(first_valid - t_start), 64'd2);
    check("addr_log_n", 64'(addr_log.size()), 64'(NW));
    check("addr_r0c0", 64'(addr_log[0]), 64'd2064);
    check("addr_r0c1", 64'(addr_log[1]), 64'd2072);
    check("addr_r1c0", 64'(addr_log[2]), 64'd2128);
    check("addr_r1c1", 64'(addr_log[3]), 64'd2136);
    check("addr_r15c0", 64'(addr_log[30]), 64'd3024);
    check("addr_r15c1", 64'(addr_log[31]), 64'd3032);

    // Five-cycle stall mid-block
    rmode = 2;
    run_fetch(32'd0, 64, 16'hFFFF, 1, 2);
    check("stall_done_lat", 64'(done_cyc - t_start), 64'(NW + 2 + 5));
    rmode = 0;

    // start while busy is ignored
    d0 = done_cnt; w0 = nword; addr_log.delete();
    push_block(32'd0, 64, 1, 2);
    do_start(32'd0, 64, 16'hFFFF, 1, 2);
    repeat (4) @(posedge clk);
    #2; mb_x = 12'd0; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    wait_done(d0 + 1, 200);
    repeat (40) @(posedge clk);
    check("busy_start_done", 64'(done_cnt - d0), 64'd1);
    check("busy_start_words", 64'(nword - w0), 64'(NW));
    check("busy_start_mem", 64'(addr_log.size()), 64'(NW));
    expq.delete();

    // Reset at word 10 aborts; a fresh fetch then starts from word 0
    d0 = done_cnt; w0 = nword;
    push_block(32'd0, 64, 1, 2);
    do_start(32'd0, 64, 16'hFFFF, 1, 2);
    for (int i = 0; i < 100 && nword - w0 < 10; i++) @(posedge clk);
    check("reach_word10", 64'(nword - w0 >= 10), 64'd1);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_abort", {busy, out_valid, done}, 64'd0);
    #1 rst = 1'b0;
    expq.delete();
    repeat (40) @(posedge clk);
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    run_fetch(32'd4096, 128, 16'hFFFF, 2, 3);

    // Address wrap modulo 2^32
    run_fetch(32'hFFFF_FFF0, 16, 16'hFFFF, 0, 0);
    check("wrap_a0", 64'(addr_log[0]), 64'hFFFF_FFF0);
    check("wrap_a1", 64'(addr_log[1]), 64'hFFFF_FFF8);
    check("wrap_a2", 64'(addr_log[2]), 64'h0000_0000);

`ifdef CUR_FETCH_BOUNDS_CHK_EN
    run_fetch(32'd0, 64, 32, 4, 0);
    run_fetch(32'd0, 64, 32, 3, 1);
`else
    // Zero stride: every row re-reads the same address
    run_fetch(32'd256, 0, 16'hFFFF, 0, 0);
    check("fw0_row1", 64'(addr_log[2]), 64'd256);
`endif

    // Randomized fetches with random backpressure
    rmode = 1;
    for (int n = 0; n < 8; n++)
      run_fetch($urandom, 8 * $urandom_range(0, 40), $urandom_range(0, 160),
                $urandom_range(0, 7), $urandom_range(0, 7));
    rmode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d compared", n_cmp);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
